// File: rtl/tss_fwd_pkg.sv
// rtl/tss_fwd_pkg.sv - shared types and constants for the forward-lookup action stage
package tss_fwd_pkg;

   typedef enum logic [1:0] {
      IDLE_S     = 2'b01,
      WAIT_ACK_S = 2'b10
   } state_t;

   localparam int DEF_PORT_NUM = 8;
   // Host queue sits just above the network ports in every bitmap.
   localparam int HOST_IDX = DEF_PORT_NUM;

endpackage

// File: rtl/popcount_tree.sv
// rtl/popcount_tree.sv - recursive combinational adder tree counting set bits
module popcount_tree #(
   parameter int WIDTH = 9,
   parameter int CNT_W = 4
) (
   input  logic [WIDTH-1:0] bits,
   output logic [CNT_W-1:0] count
);

   generate
      if (WIDTH == 1) begin : g_leaf
         assign count = CNT_W'(bits);
      end else begin : g_node
         localparam int LO = WIDTH / 2;
         logic [CNT_W-1:0] cnt_lo;
         logic [CNT_W-1:0] cnt_hi;

         popcount_tree #(.WIDTH(LO), .CNT_W(CNT_W)) u_lo (
            .bits  (bits[LO-1:0]),
            .count (cnt_lo)
         );
         popcount_tree #(.WIDTH(WIDTH-LO), .CNT_W(CNT_W)) u_hi (
            .bits  (bits[WIDTH-1:LO]),
            .count (cnt_hi)
         );

         assign count = cnt_lo + cnt_hi;
      end
   endgenerate

endmodule

// File: rtl/multicast_packet_action.sv
// rtl/multicast_packet_action.sv - fans a lookup result out to port/host queues and the buffer manager
module multicast_packet_action
   import tss_fwd_pkg::*;
#(
   parameter int PORT_NUM = DEF_PORT_NUM,
   parameter int BUFID_W  = 9,
   parameter int TYPE_W   = 3,
   parameter int INPORT_W = 4,
   localparam int CNT_W   = $clog2(PORT_NUM + 2)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [PORT_NUM:0]   iv_outport,
   input  logic                i_mac_entry_hit,
   input  logic [BUFID_W-1:0]  iv_pkt_bufid,
   input  logic [TYPE_W-1:0]   iv_pkt_type,
   input  logic [INPORT_W-1:0] iv_pkt_inport,
   input  logic                i_action_req,
   output logic                o_action_ack,
   output logic [BUFID_W-1:0]  ov_pkt_bufid_out,
   output logic [TYPE_W-1:0]   ov_pkt_type_out,
   output logic [INPORT_W-1:0] ov_pkt_inport_host,
   output logic                o_mac_entry_hit_host,
   output logic [PORT_NUM:0]   ov_pkt_bufid_req,
   input  logic [PORT_NUM:0]   iv_pkt_bufid_ack,
   output logic [BUFID_W-1:0]  ov_cnt_bufid,
   output logic [CNT_W-1:0]    ov_pkt_bufid_cnt,
   output logic                o_cnt_req,
   input  logic                i_cnt_ack
);

   localparam logic [PORT_NUM:0] HOST_ONLY = (PORT_NUM+1)'(1) << PORT_NUM;

   state_t              state, state_nxt;
   logic                ack_nxt, hit_nxt, cnt_req_nxt, clear;
   logic [BUFID_W-1:0]  bufid_nxt;
   logic [TYPE_W-1:0]   type_nxt;
   logic [INPORT_W-1:0] inport_nxt;
   logic [PORT_NUM:0]   req_nxt, eff_mask;
   logic [CNT_W-1:0]    cnt_nxt, mask_cnt;

   // An empty bitmap means "no network port matched": deliver to the host.
   assign eff_mask = (iv_outport == '0) ? HOST_ONLY : iv_outport;

   popcount_tree #(.WIDTH(PORT_NUM+1), .CNT_W(CNT_W)) u_popcount (
      .bits  (eff_mask),
      .count (mask_cnt)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state                <= IDLE_S;
         o_action_ack         <= 1'b0;
         ov_pkt_bufid_out     <= '0;
         ov_pkt_type_out      <= '0;
         ov_pkt_inport_host   <= '0;
         o_mac_entry_hit_host <= 1'b0;
         ov_pkt_bufid_req     <= '0;
         ov_cnt_bufid         <= '0;
         ov_pkt_bufid_cnt     <= '0;
         o_cnt_req            <= 1'b0;
      end else begin
         state                <= state_nxt;
         o_action_ack         <= ack_nxt;
         ov_pkt_bufid_out     <= bufid_nxt;
         ov_pkt_type_out      <= type_nxt;
         ov_pkt_inport_host   <= inport_nxt;
         o_mac_entry_hit_host <= hit_nxt;
         ov_pkt_bufid_req     <= req_nxt;
         ov_cnt_bufid         <= bufid_nxt;
         ov_pkt_bufid_cnt     <= cnt_nxt;
         o_cnt_req            <= cnt_req_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ack_nxt     = 1'b0;
      bufid_nxt   = ov_pkt_bufid_out;
      type_nxt    = ov_pkt_type_out;
      inport_nxt  = ov_pkt_inport_host;
      hit_nxt     = o_mac_entry_hit_host;
      req_nxt     = ov_pkt_bufid_req;
      cnt_nxt     = ov_pkt_bufid_cnt;
      cnt_req_nxt = o_cnt_req;
      clear       = 1'b0;
      case (state)
         IDLE_S: begin
            if (i_action_req) begin
               state_nxt   = WAIT_ACK_S;
               ack_nxt     = 1'b1;
               bufid_nxt   = iv_pkt_bufid;
               type_nxt    = iv_pkt_type;
               inport_nxt  = iv_pkt_inport;
               hit_nxt     = i_mac_entry_hit;
               req_nxt     = eff_mask;
               cnt_nxt     = mask_cnt;
               cnt_req_nxt = 1'b1;
            end else begin
               clear = 1'b1;
            end
         end
         WAIT_ACK_S: begin
            // Acks on idle channels are masked off by the AND with the pending request.
            if (((ov_pkt_bufid_req & ~iv_pkt_bufid_ack) == '0) && !(o_cnt_req && !i_cnt_ack)) begin
               state_nxt = IDLE_S;
               clear     = 1'b1;
            end else begin
               req_nxt     = ov_pkt_bufid_req & ~iv_pkt_bufid_ack;
               cnt_req_nxt = o_cnt_req & ~i_cnt_ack;
            end
         end
         default: begin
            state_nxt = IDLE_S;
            clear     = 1'b1;
         end
      endcase
      if (clear) begin
         bufid_nxt   = '0;
         type_nxt    = '0;
         inport_nxt  = '0;
         hit_nxt     = 1'b0;
         req_nxt     = '0;
         cnt_nxt     = '0;
         cnt_req_nxt = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicast_packet_action.sv
// tb/tb_multicast_packet_action.sv - directed self-checking bench for multicast_packet_action
module tb_multicast_packet_action;
   import tss_fwd_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] outport;
   logic       hit;
   logic [8:0] bufid;
   logic [2:0] ptype;
   logic [3:0] inport;
   logic       action_req;
   logic       action_ack;
   logic [8:0] bufid_out;
   logic [2:0] type_out;
   logic [3:0] inport_host;
   logic       hit_host;
   logic [8:0] bufid_req;
   logic [8:0] bufid_ack;
   logic [8:0] cnt_bufid;
   logic [3:0] bufid_cnt;
   logic       cnt_req;
   logic       cnt_ack;

   int checks = 0;
   int errors = 0;
   int ack_seen;
   logic [8:0] exp_req;
   logic [8:0] host_bit;

   multicast_packet_action dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .iv_outport           (outport),
      .i_mac_entry_hit      (hit),
      .iv_pkt_bufid         (bufid),
      .iv_pkt_type          (ptype),
      .iv_pkt_inport        (inport),
      .i_action_req         (action_req),
      .o_action_ack         (action_ack),
      .ov_pkt_bufid_out     (bufid_out),
      .ov_pkt_type_out      (type_out),
      .ov_pkt_inport_host   (inport_host),
      .o_mac_entry_hit_host (hit_host),
      .ov_pkt_bufid_req     (bufid_req),
      .iv_pkt_bufid_ack     (bufid_ack),
      .ov_cnt_bufid         (cnt_bufid),
      .ov_pkt_bufid_cnt     (bufid_cnt),
      .o_cnt_req            (cnt_req),
      .i_cnt_ack            (cnt_ack)
   );

   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, 32'(dut.state), 32'(IDLE_S));
      check({tag, "_req"}, 32'(bufid_req), 32'h0);
      check({tag, "_cnt_req"}, 32'(cnt_req), 32'h0);
      check({tag, "_bufid"}, 32'(bufid_out), 32'h0);
      check({tag, "_ack"}, 32'(action_ack), 32'h0);
   endtask

   task automatic issue(input logic [8:0] op, input logic [8:0] bid, input logic [2:0] ty,
                        input logic [3:0] inp, input logic h);
      outport = op; bufid = bid; ptype = ty; inport = inp; hit = h; action_req = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      host_bit = 9'h1 << HOST_IDX;
      rst_n = 1'b0; outport = '0; hit = 1'b0; bufid = '0; ptype = '0; inport = '0;
      action_req = 1'b0; bufid_ack = '0; cnt_ack = 1'b0;
      tick(); tick();
      check_idle("reset");
      check("reset_cnt", 32'(bufid_cnt), 32'h0);
      rst_n = 1'b1;
      tick();

      // unicast, simultaneous final acks
      issue(9'h004, 9'h05A, 3'd3, 4'h1, 1'b1);
      action_req = 1'b0;
      check("uni_req", 32'(bufid_req), 32'h004);
      check("uni_bufid", 32'(bufid_out), 32'h05A);
      check("uni_type", 32'(type_out), 32'h3);
      check("uni_cnt", 32'(bufid_cnt), 32'h1);
      check("uni_cnt_bufid", 32'(cnt_bufid), 32'h05A);
      check("uni_cnt_req", 32'(cnt_req), 32'h1);
      check("uni_ack", 32'(action_ack), 32'h1);
      bufid_ack = 9'h004; cnt_ack = 1'b1;
      tick();
      bufid_ack = '0; cnt_ack = 1'b0;
      check_idle("uni_done");

      // zero bitmap goes to host
      issue(9'h000, 9'h011, 3'd1, 4'h3, 1'b0);
      action_req = 1'b0;
      check("zero_req", 32'(bufid_req), 32'(host_bit));
      check("zero_cnt", 32'(bufid_cnt), 32'h1);
      check("zero_inport", 32'(inport_host), 32'h3);
      check("zero_hit", 32'(hit_host), 32'h0);
      tick();
      check("zero_ack_once", 32'(action_ack), 32'h0);
      check("zero_hold", 32'(bufid_req), 32'h100);
      bufid_ack = 9'h100;
      tick();
      bufid_ack = '0;
      check("zero_req_clr", 32'(bufid_req), 32'h0);
      check("zero_cnt_pend", 32'(cnt_req), 32'h1);
      check("zero_state", 32'(dut.state), 32'(WAIT_ACK_S));
      cnt_ack = 1'b1;
      tick();
      cnt_ack = 1'b0;
      check_idle("zero_done");

      // staggered multicast to every channel
      issue(9'h1FF, 9'h1A5, 3'd5, 4'h7, 1'b1);
      action_req = 1'b0;
      check("mc_cnt", 32'(bufid_cnt), 32'd9);
      check("mc_req", 32'(bufid_req), 32'h1FF);
      for (int k = 0; k < 9; k++) begin
         bufid_ack = 9'h1 << k;
         tick();
         exp_req = 9'h1FF << (k + 1);
         check($sformatf("mc_req_%0d", k), 32'(bufid_req), 32'(exp_req));
         check($sformatf("mc_bufid_%0d", k), 32'(bufid_out), 32'h1A5);
         check($sformatf("mc_ack_%0d", k), 32'(action_ack), 32'h0);
         check($sformatf("mc_state_%0d", k), 32'(dut.state), 32'(WAIT_ACK_S));
      end
      bufid_ack = '0; cnt_ack = 1'b1;
      tick();
      cnt_ack = 1'b0;
      check_idle("mc_done");

      // spurious ack on an unaddressed channel
      issue(9'h003, 9'h077, 3'd2, 4'h2, 1'b1);
      action_req = 1'b0;
      check("sp_cnt", 32'(bufid_cnt), 32'd2);
      bufid_ack = 9'h020;
      tick();
      check("sp_ignored", 32'(bufid_req), 32'h003);
      check("sp_state", 32'(dut.state), 32'(WAIT_ACK_S));
      bufid_ack = 9'h001;
      tick();
      check("sp_req0", 32'(bufid_req), 32'h002);
      bufid_ack = 9'h002;
      tick();
      check("sp_req1", 32'(bufid_req), 32'h000);
      check("sp_state2", 32'(dut.state), 32'(WAIT_ACK_S));
      bufid_ack = '0; cnt_ack = 1'b1;
      tick();
      cnt_ack = 1'b0;
      check_idle("sp_done");

      // back-to-back with request held high
      ack_seen = 0;
      issue(9'h010, 9'h0A1, 3'd4, 4'h5, 1'b0);
      if (action_ack) ack_seen++;
      check("bb_bufid1", 32'(bufid_out), 32'h0A1);
      outport = 9'h020; bufid = 9'h0B2; ptype = 3'd6;
      tick();
      if (action_ack) ack_seen++;
      check("bb_stable", 32'(bufid_out), 32'h0A1);
      check("bb_wait", 32'(dut.state), 32'(WAIT_ACK_S));
      bufid_ack = 9'h010; cnt_ack = 1'b1;
      tick();
      if (action_ack) ack_seen++;
      bufid_ack = '0; cnt_ack = 1'b0;
      check("bb_idle", 32'(dut.state), 32'(IDLE_S));
      check("bb_idle_ack", 32'(action_ack), 32'h0);
      tick();
      if (action_ack) ack_seen++;
      action_req = 1'b0;
      check("bb_ack2", 32'(action_ack), 32'h1);
      check("bb_bufid2", 32'(bufid_out), 32'h0B2);
      check("bb_req2", 32'(bufid_req), 32'h020);
      check("bb_type2", 32'(type_out), 32'h6);
      bufid_ack = 9'h020; cnt_ack = 1'b1;
      tick();
      if (action_ack) ack_seen++;
      bufid_ack = '0; cnt_ack = 1'b0;
      check("bb_ack_count", 32'(ack_seen), 32'd2);
      check_idle("bb_done");

      // asynchronous reset mid-transaction
      issue(9'h0F0, 9'h0EE, 3'd7, 4'hF, 1'b1);
      action_req = 1'b0;
      tick();
      check("rst_pend", 32'(bufid_req), 32'h0F0);
      #1 rst_n = 1'b0;
      #1;
      check("rst_req", 32'(bufid_req), 32'h0);
      check("rst_cnt_req", 32'(cnt_req), 32'h0);
      check("rst_bufid", 32'(bufid_out), 32'h0);
      check("rst_cnt", 32'(bufid_cnt), 32'h0);
      check("rst_hit", 32'(hit_host), 32'h0);
      tick();
      rst_n = 1'b1;
      check_idle("rst_after");
      issue(9'h001, 9'h0C3, 3'd1, 4'h0, 1'b0);
      action_req = 1'b0;
      check("post_req", 32'(bufid_req), 32'h001);
      check("post_cnt", 32'(bufid_cnt), 32'h1);
      check("post_ack", 32'(action_ack), 32'h1);
      bufid_ack = 9'h001; cnt_ack = 1'b1;
      tick();
      bufid_ack = '0; cnt_ack = 1'b0;
      check_idle("post_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
